// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - UART byte stream to double-buffered frame RAM loader
// Packs 3 colour bytes per pixel into the back bank and swaps banks on a scan-frame boundary.
module frame_loader #(
  parameter int         LENGTH    = 5,
  parameter int         SCAN_BIT  = 3,
  parameter int         BITDEPTH  = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         TIMEOUT   = 100000,
  localparam int        PIXELS    = 2*LENGTH*(1<<SCAN_BIT),
  localparam int        AW        = $clog2(PIXELS),
  localparam int        TW        = $clog2(TIMEOUT+1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic                  o_wr_en,
  output logic [AW-1:0]         o_wr_addr,
  output logic [3*BITDEPTH-1:0] o_wr_data,
  output logic                  o_wr_bank,
  output logic                  o_disp_bank,
  input  logic                  i_frame_start,
  output logic                  o_swapped,
  output logic                  o_abort
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WAIT_SWAP} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_rx_ready;
  logic                  r_wr_en;
  logic [AW-1:0]         r_wr_addr;
  logic [3*BITDEPTH-1:0] r_wr_data;
  logic                  r_wr_bank;
  logic                  r_disp_bank;
  logic                  r_swapped;
  logic                  r_abort;
  logic [1:0]            r_idx;
  logic [TW-1:0]         r_tcnt;

  logic w_hs;
  logic w_recv_hs;
  logic w_sync;
  logic w_third;
  logic w_expire;
  logic w_swap;

  assign w_hs      = i_rx_valid && r_rx_ready;
  assign w_recv_hs = w_hs && (r_state == S_RECV);
  assign w_sync    = w_hs && (r_state == S_IDLE) && (i_rx_data == SYNC_BYTE);
  assign w_third   = w_recv_hs && (r_idx == 2'd2);
  assign w_expire  = (r_state == S_RECV) && !w_hs && (r_tcnt == TW'(TIMEOUT-1));
  // A frame_start landing on the final write cycle must not swap a bank still being written.
  assign w_swap    = (r_state == S_WAIT_SWAP) && i_frame_start && !r_wr_en;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_sync) w_next = S_RECV;
      S_RECV: begin
        if (w_third && (r_wr_addr == AW'(PIXELS-1))) w_next = S_WAIT_SWAP;
        else if (w_expire)                           w_next = S_IDLE;
      end
      S_WAIT_SWAP: if (w_swap) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_ready  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_wr_bank   <= 1'b1;
      r_disp_bank <= 1'b0;
      r_swapped   <= 1'b0;
      r_abort     <= 1'b0;
      r_idx       <= 2'd0;
      r_tcnt      <= '0;
    end else begin
      r_rx_ready <= (w_next != S_WAIT_SWAP);
      r_wr_en    <= w_third;
      r_swapped  <= w_swap;
      r_abort    <= w_expire;
      if (w_swap) begin
        r_disp_bank <= ~r_disp_bank;
        r_wr_bank   <= r_disp_bank;
      end
      if ((r_state != S_RECV) || w_hs || w_expire) r_tcnt <= '0;
      else                                         r_tcnt <= r_tcnt + 1'b1;
      if (w_sync || w_expire) begin
        r_idx     <= 2'd0;
        r_wr_addr <= '0;
      end else begin
        if (w_recv_hs) r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
        if (r_wr_en)   r_wr_addr <= (r_wr_addr == AW'(PIXELS-1)) ? '0 : r_wr_addr + 1'b1;
      end
      if (w_recv_hs) begin
        for (int c = 0; c < 3; c++) begin
          if (r_idx == 2'(c)) r_wr_data[c*BITDEPTH +: BITDEPTH] <= i_rx_data[7 -: BITDEPTH];
        end
      end
    end
  end

  assign o_rx_ready  = r_rx_ready;
  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_wr_bank   = r_wr_bank;
  assign o_disp_bank = r_disp_bank;
  assign o_swapped   = r_swapped;
  assign o_abort     = r_abort;

endmodule

// File: tb/tb_frame_loader.sv
// tb/tb_frame_loader.sv - directed self-checking bench for frame_loader
// Default geometry (80 pixels), timeout shortened to 50 cycles.
module tb_frame_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [23:0] wr_data;
  logic        wr_bank;
  logic        disp_bank;
  logic        frame_start = 1'b0;
  logic        swapped;
  logic        abort;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_hs = 0;
  int swap_cnt = 0;
  int abort_cnt = 0;
  int abort_cyc = 0;
  logic [6:0]  waddr_q[$];
  logic [23:0] wdata_q[$];

  frame_loader #(.TIMEOUT(50)) dut (
    .i_clk(clk), .i_reset(reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_ready(rx_ready), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_wr_bank(wr_bank), .o_disp_bank(disp_bank), .i_frame_start(frame_start),
    .o_swapped(swapped), .o_abort(abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      waddr_q.push_back(wr_addr);
      wdata_q.push_back(wr_data);
    end
    if (swapped) swap_cnt++;
    if (abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        last_hs = cyc;
      end
    end
    rx_valid = 1'b0;
    if (!ok) check("rx_accept", 32'd0, 32'd1);
  endtask

  task automatic send_pixels(input int nbytes);
    for (int k = 0; k < nbytes; k++) send_byte(8'((k / 3) + (k % 3)));
  endtask

  task automatic check_frame(input string tag, input int base);
    int n;
    int errs;
    logic [23:0] exp;
    n = waddr_q.size() - base;
    errs = 0;
    check({tag, "_writes"}, 32'(n), 32'd80);
    for (int p = 0; p < 80 && p < n; p++) begin
      exp = {8'(p + 2), 8'(p + 1), 8'(p)};
      if (waddr_q[base+p] !== 7'(p) || wdata_q[base+p] !== exp) errs++;
    end
    check({tag, "_content_errs"}, 32'(errs), 32'd0);
    if (n >= 80) check({tag, "_last_word"}, 32'(wdata_q[base+79]), 32'h0051504F);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
    check({tag, "_wr_en"},     32'(wr_en),     32'd0);
    check({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
    check({tag, "_wr_data"},   32'(wr_data),   32'd0);
    check({tag, "_disp_bank"}, 32'(disp_bank), 32'd0);
    check({tag, "_wr_bank"},   32'(wr_bank),   32'd1);
    check({tag, "_swapped"},   32'(swapped),   32'd0);
    check({tag, "_abort"},     32'(abort),     32'd0);
  endtask

  initial begin
    int base;
    int s0;
    int a0;
    int rdy_cnt;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    // full frame, then swap on frame_start
    base = waddr_q.size();
    send_byte(8'hA5);
    send_pixels(240);
    idle(3);
    check_frame("frame1", base);
    check("frame1_disp_before", 32'(disp_bank), 32'd0);
    check("frame1_ready_wait", 32'(rx_ready), 32'd0);
    check("frame1_no_swap_yet", 32'(swap_cnt), 32'd0);
    frame_start = 1'b1;
    idle(1);
    frame_start = 1'b0;
    idle(2);
    check("frame1_swap_cnt", 32'(swap_cnt), 32'd1);
    check("frame1_disp_after", 32'(disp_bank), 32'd1);
    check("frame1_wr_bank_after", 32'(wr_bank), 32'd0);
    check("frame1_ready_idle", 32'(rx_ready), 32'd1);

    // junk before sync is discarded
    base = waddr_q.size();
    send_byte(8'h00);
    send_byte(8'h13);
    idle(3);
    check("junk_no_write", 32'(waddr_q.size() - base), 32'd0);
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    idle(3);
    check("sync_first_write_cnt", 32'(waddr_q.size() - base), 32'd1);
    check("sync_first_addr", 32'(waddr_q[base]), 32'd0);
    check("sync_first_data", 32'(wdata_q[base]), 32'h00332211);

    // sync byte value mid-frame is plain data
    send_byte(8'hA5);
    send_byte(8'hA5);
    send_byte(8'hA5);
    idle(3);
    check("a5_data_write_cnt", 32'(waddr_q.size() - base), 32'd2);
    check("a5_data_addr", 32'(waddr_q[base+1]), 32'd1);
    check("a5_data_word", 32'(wdata_q[base+1]), 32'h00A5A5A5);

    // 7th byte then silence: abort 50 cycles after the last handshake
    a0 = abort_cnt;
    s0 = swap_cnt;
    send_byte(8'h42);
    for (int i = 0; i < 200 && abort_cnt == a0; i++) @(negedge clk);
    idle(3);
    check("timeout_abort_cnt", 32'(abort_cnt - a0), 32'd1);
    check("timeout_abort_delay", 32'(abort_cyc - last_hs), 32'd50);
    check("timeout_writes", 32'(waddr_q.size() - base), 32'd2);
    check("timeout_no_swap", 32'(swap_cnt - s0), 32'd0);
    check("timeout_disp_kept", 32'(disp_bank), 32'd1);
    check("timeout_idle_ready", 32'(rx_ready), 32'd1);

    // reset 30 bytes into a frame
    send_byte(8'hA5);
    send_pixels(30);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("midreset");
    reset = 1'b0;

    // new frame from addr 0; frame_start coincident with the final write is ignored
    base = waddr_q.size();
    s0 = swap_cnt;
    send_byte(8'hA5);
    send_pixels(239);
    send_byte(8'd81);
    frame_start = 1'b1;
    @(negedge clk);
    check("coincide_wr_en", 32'(wr_en), 32'd1);
    check("coincide_ready", 32'(rx_ready), 32'd0);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    idle(2);
    check("coincide_no_swap", 32'(swap_cnt - s0), 32'd0);
    check("coincide_disp", 32'(disp_bank), 32'd0);
    check_frame("frame2", base);
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    rdy_cnt  = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rx_ready) rdy_cnt++;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("wait_swap_no_accept", 32'(rdy_cnt), 32'd0);
    check("wait_swap_no_write", 32'(waddr_q.size() - base), 32'd80);
    frame_start = 1'b1;
    idle(1);
    frame_start = 1'b0;
    idle(2);
    check("late_swap_cnt", 32'(swap_cnt - s0), 32'd1);
    check("late_swap_disp", 32'(disp_bank), 32'd1);
    check("late_swap_wr_bank", 32'(wr_bank), 32'd0);
    check("late_swap_ready", 32'(rx_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
